// File: rtl/freq_fsk_pkg.sv
// Shared types and helpers for the multi-level FSK codec.
// Defaults mirror the top-level parameter defaults; derived sizes are recomputed per instance.
package freq_fsk_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int SYM_W_DEF       = 2;
  localparam int BASE_HALF_DEF   = 8;
  localparam int STEP_HALF_DEF   = 4;
  localparam int SYM_PERIODS_DEF = 2;
  localparam int TIMEOUT_DEF     = 64;

  localparam int NSYM  = DATA_W_DEF / SYM_W_DEF;
  localparam int NHALF = 2 * SYM_PERIODS_DEF;
  localparam int HMAX  = BASE_HALF_DEF + (2**SYM_W_DEF - 1) * STEP_HALF_DEF;
  localparam int CNT_W = $clog2(TIMEOUT_DEF + 1);

  typedef enum logic [1:0] {
    ENC_IDLE,
    ENC_SYM,
    ENC_STOP,
    ENC_GAP
  } enc_state_e;

  function automatic int half_of(input int k, input int base, input int step);
    return base + k * step;
  endfunction

endpackage

// File: rtl/freq_fsk_codec_classifier.sv
// Combinational interval classifier: maps a measured half-period m to symbol k within +/-TOL.
// Zero latency; no flow control.
module freq_sym_classifier
  import freq_fsk_pkg::*;
#(
  parameter int SYM_W     = 2,
  parameter int BASE_HALF = 8,
  parameter int STEP_HALF = 4,
  parameter int TOL       = 1,
  parameter int M_W       = 7
) (
  input  logic [M_W-1:0]   m_i,
  output logic             vld_o,
  output logic [SYM_W-1:0] k_o
);

  // Tolerance windows are disjoint because TOL < STEP_HALF/2, so at most one k matches.
  always_comb begin
    vld_o = 1'b0;
    k_o   = '0;
    for (int k = 0; k < 2**SYM_W; k++) begin
      if ((int'(m_i) >= half_of(k, BASE_HALF, STEP_HALF) - TOL) &&
          (int'(m_i) <= half_of(k, BASE_HALF, STEP_HALF) + TOL)) begin
        vld_o = 1'b1;
        k_o   = SYM_W'(k);
      end
    end
  end

endmodule

// File: rtl/freq_fsk_codec.sv
// Multi-level FSK codec: word-to-square-wave encoder FSM plus edge-interval decoder.
// One word per tx_valid/tx_ready handshake; rx strobes appear one cycle after the closing edge.
module freq_fsk_codec
  import freq_fsk_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYM_W       = SYM_W_DEF,
  parameter int BASE_HALF   = BASE_HALF_DEF,
  parameter int STEP_HALF   = STEP_HALF_DEF,
  parameter int TOL         = 1,
  parameter int SYM_PERIODS = SYM_PERIODS_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              loopback,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              pulse_out,
  input  logic              pulse_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              tx_busy
);

  localparam int SYMS   = DATA_W / SYM_W;
  localparam int HALVES = 2 * SYM_PERIODS;
  localparam int DCNT_W = $clog2(TIMEOUT + 1);
  localparam int ECNT_W = $clog2(TIMEOUT + 3);
  localparam int SIDX_W = $clog2(SYMS + 1);
  localparam int HIDX_W = $clog2(HALVES + 1);

  enc_state_e        enc_q;
  logic [DATA_W-1:0] word_q;
  logic [SIDX_W-1:0] esym_q;
  logic [HIDX_W-1:0] ehalf_q;
  logic [ECNT_W-1:0] ecnt_q;
  logic              pulse_q;
  logic              tx_ready_q;
  logic              tx_busy_q;
  logic [ECNT_W-1:0] half_end;

  // The symbol in flight always sits in the top bits; word_q shifts left per symbol.
  assign half_end = ECNT_W'(half_of(int'(word_q[DATA_W-1 -: SYM_W]), BASE_HALF, STEP_HALF) - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_q      <= ENC_IDLE;
      word_q     <= '0;
      esym_q     <= '0;
      ehalf_q    <= '0;
      ecnt_q     <= '0;
      pulse_q    <= 1'b0;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else if (ena) begin
      unique case (enc_q)
        ENC_IDLE: begin
          if (tx_valid && tx_ready_q) begin
            word_q     <= tx_data;
            enc_q      <= ENC_SYM;
            pulse_q    <= 1'b1;
            tx_ready_q <= 1'b0;
            tx_busy_q  <= 1'b1;
            ecnt_q     <= '0;
            esym_q     <= '0;
            ehalf_q    <= '0;
          end
        end
        ENC_SYM: begin
          if (ecnt_q == half_end) begin
            ecnt_q <= '0;
            if (ehalf_q == HIDX_W'(HALVES - 1)) begin
              // Each symbol ends low, so the next symbol (or stop pulse) starts with a rising edge.
              ehalf_q <= '0;
              pulse_q <= 1'b1;
              if (esym_q == SIDX_W'(SYMS - 1)) begin
                enc_q <= ENC_STOP;
              end else begin
                esym_q <= esym_q + 1'b1;
                word_q <= word_q << SYM_W;
              end
            end else begin
              ehalf_q <= ehalf_q + 1'b1;
              pulse_q <= ~pulse_q;
            end
          end else begin
            ecnt_q <= ecnt_q + 1'b1;
          end
        end
        ENC_STOP: begin
          if (ecnt_q == ECNT_W'(BASE_HALF - 1)) begin
            ecnt_q  <= '0;
            enc_q   <= ENC_GAP;
            pulse_q <= 1'b0;
          end else begin
            ecnt_q <= ecnt_q + 1'b1;
          end
        end
        ENC_GAP: begin
          if (ecnt_q == ECNT_W'(TIMEOUT + 1)) begin
            ecnt_q     <= '0;
            enc_q      <= ENC_IDLE;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
          end else begin
            ecnt_q <= ecnt_q + 1'b1;
          end
        end
        default: enc_q <= ENC_IDLE;
      endcase
    end
  end

  logic              line;
  logic              sync1_q, sync2_q, prev_q;
  logic              edge_det;
  logic [DCNT_W-1:0] dcnt_q;
  logic              active_q, skip_q, bad_q;
  logic [HIDX_W-1:0] dhalf_q;
  logic [SIDX_W-1:0] dsym_q;
  logic [SYM_W-1:0]  symk_q;
  logic [DATA_W-1:0] shift_q, rx_data_q;
  logic              rx_valid_q, rx_err_q;
  logic              cls_vld;
  logic [SYM_W-1:0]  cls_k;
  logic              timeout, partial, iv_bad, sym_done, word_done;
  logic [DATA_W-1:0] shift_d;

  assign line     = loopback ? pulse_q : pulse_in;
  assign edge_det = sync2_q ^ prev_q;

  freq_sym_classifier #(
    .SYM_W    (SYM_W),
    .BASE_HALF(BASE_HALF),
    .STEP_HALF(STEP_HALF),
    .TOL      (TOL),
    .M_W      (DCNT_W)
  ) u_cls (
    .m_i  (dcnt_q),
    .vld_o(cls_vld),
    .k_o  (cls_k)
  );

  always_comb begin
    timeout   = active_q && (dcnt_q == DCNT_W'(TIMEOUT));
    partial   = (dsym_q != '0) || (dhalf_q != '0);
    iv_bad    = !cls_vld || ((dhalf_q != '0) && (cls_k != symk_q));
    sym_done  = (dhalf_q == HIDX_W'(HALVES - 1));
    word_done = sym_done && (dsym_q == SIDX_W'(SYMS - 1));
    shift_d   = {shift_q[DATA_W-SYM_W-1:0], symk_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      dcnt_q     <= '0;
      active_q   <= 1'b0;
      skip_q     <= 1'b0;
      bad_q      <= 1'b0;
      dhalf_q    <= '0;
      dsym_q     <= '0;
      symk_q     <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else if (ena) begin
      sync1_q    <= line;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (edge_det) begin
        dcnt_q <= DCNT_W'(1);
      end else if (dcnt_q != DCNT_W'(TIMEOUT)) begin
        dcnt_q <= dcnt_q + 1'b1;
      end
      // A coincident edge survives the timeout as the first edge of the next frame.
      if (timeout) begin
        active_q <= edge_det;
        skip_q   <= 1'b0;
        bad_q    <= 1'b0;
        dhalf_q  <= '0;
        dsym_q   <= '0;
        rx_err_q <= partial;
      end else if (edge_det) begin
        if (!active_q) begin
          active_q <= 1'b1;
        end else if (skip_q) begin
          skip_q <= 1'b0;
        end else begin
          if (dhalf_q == '0) begin
            symk_q <= cls_k;
          end
          if (sym_done) begin
            dhalf_q <= '0;
            shift_q <= shift_d;
            if (word_done) begin
              dsym_q <= '0;
              bad_q  <= 1'b0;
              skip_q <= 1'b1;
              if (bad_q || iv_bad) begin
                rx_err_q <= 1'b1;
              end else begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= shift_d;
              end
            end else begin
              dsym_q <= dsym_q + 1'b1;
              bad_q  <= bad_q | iv_bad;
            end
          end else begin
            dhalf_q <= dhalf_q + 1'b1;
            bad_q   <= bad_q | iv_bad;
          end
        end
      end
    end
  end

  assign tx_ready  = tx_ready_q;
  assign tx_busy   = tx_busy_q;
  assign pulse_out = pulse_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q & ena;
  assign rx_err    = rx_err_q & ena;

endmodule
